// File: rtl/fir_mul_sched.sv
// Round-robin scheduler that shares one pipelined FP multiplier among NREQ FIR tap requesters.
// Optional sticky exception flags are enabled by defining FIRMUL_STICKY_FLAGS_EN.
module fir_mul_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = 3,
    parameter int unsigned WDATA = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WDATA-1:0]   req_a,
    input  logic [NREQ*WDATA-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic                    mul_valid,
    output logic [WDATA-1:0]        mul_a,
    output logic [WDATA-1:0]        mul_b,
    output logic [1:0]              mul_rmode,
    input  logic [WDATA-1:0]        mul_res,
    input  logic                    mul_inexact,
    input  logic                    mul_overflow,
    input  logic                    mul_tiny,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WDATA-1:0]        rsp_data,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_rmode,
    output logic                    cfg_busy,
    input  logic                    flag_clr,
    output logic                    flag_inexact,
    output logic                    flag_overflow,
    output logic                    flag_tiny
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, UPDATE} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic [1:0]      pend_rmode;
    logic [NREQ-1:0] tag_q [LAT];

    logic [PW-1:0]   cand;
    logic [PW-1:0]   gidx;
    logic            found;
    logic [WDATA-1:0] sel_a;
    logic [WDATA-1:0] sel_b;
    logic            issue;
    logic            ret;

    // Round-robin pick: first requester at or after ptr, wrapping; grants only in RUN
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(ptr) + k) % NREQ);
            if (!found && req[cand] && (state == RUN)) begin
                gnt[cand] = 1'b1;
                gidx      = cand;
                found     = 1'b1;
            end
        end
    end

    // One-hot operand mux driven by the grant
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_a = sel_a | req_a[i*WDATA +: WDATA];
                sel_b = sel_b | req_b[i*WDATA +: WDATA];
            end
        end
    end

    assign issue    = |gnt;
    assign ret      = |tag_q[LAT-1];
    assign rsp_data = mul_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            ptr        <= '0;
            count      <= '0;
            pend_rmode <= 2'b00;
            mul_rmode  <= 2'b00;
            mul_valid  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_valid  <= '0;
            cfg_busy   <= 1'b0;
            for (int s = 0; s < int'(LAT); s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            mul_valid <= issue;
            if (issue) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
                ptr   <= PW'((32'(gidx) + 32'd1) % NREQ);
            end

            // Tag pipe: the one-hot grant travels alongside the multiplier; rsp_valid lines up with mul_res
            tag_q[0] <= gnt;
            for (int s = int'(LAT) - 1; s > 0; s--) begin
                tag_q[s] <= tag_q[s-1];
            end
            rsp_valid <= tag_q[LAT-1];

            if (issue && !ret) begin
                count <= count + CW'(1);
            end else if (!issue && ret) begin
                count <= count - CW'(1);
            end

            case (state)
                RUN: begin
                    if (cfg_we) begin
                        pend_rmode <= cfg_rmode;
                        state      <= DRAIN;
                        cfg_busy   <= 1'b1;
                    end
                end
                DRAIN: begin
                    // count already includes any op issued on the RUN->DRAIN edge
                    if (count == '0) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    mul_rmode <= pend_rmode;
                    state     <= RUN;
                    cfg_busy  <= 1'b0;
                end
                default: begin
                    state    <= RUN;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIRMUL_STICKY_FLAGS_EN
    logic rsp_any;
    assign rsp_any = |rsp_valid;

    // A set event in the same cycle as flag_clr wins
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_inexact  <= 1'b0;
            flag_overflow <= 1'b0;
            flag_tiny     <= 1'b0;
        end else begin
            flag_inexact  <= (flag_inexact  & ~flag_clr) | (rsp_any & mul_inexact);
            flag_overflow <= (flag_overflow & ~flag_clr) | (rsp_any & mul_overflow);
            flag_tiny     <= (flag_tiny     & ~flag_clr) | (rsp_any & mul_tiny);
        end
    end
`else
    logic unused_flags;
    assign unused_flags  = ^{flag_clr, mul_inexact, mul_overflow, mul_tiny};
    assign flag_inexact  = 1'b0;
    assign flag_overflow = 1'b0;
    assign flag_tiny     = 1'b0;
`endif

endmodule
